aq_spsram_ctrl: RTL

Request-side controller that sits directly upstream of the 2048x32 single-port SRAM wrapper and drives its A/CEN/D/GWEN/WEN/Q interface. It zero-fills the array after reset, then converts a valid/ready word request stream (read, or byte-masked write) into SRAM accesses. Read data returns on a valid/ready response channel with a 2-entry skid buffer, so the consumer can stall without losing data.

---
 rtl/aq_spsram_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/aq_spsram_ctrl.sv
// Request-side controller for a single-port SRAM: zero-fills the array after reset, then maps a
// valid/ready word request stream onto SRAM accesses with a 2-entry skid buffer on read data.
module aq_spsram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   ram_a,
    output logic                    ram_cen,
    output logic [DATA_WIDTH-1:0]   ram_d,
    output logic                    ram_gwen,
    output logic [DATA_WIDTH-1:0]   ram_wen,
    input  logic [DATA_WIDTH-1:0]   ram_q
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                       state_q;
    logic [ADDR_WIDTH-1:0]        cnt_q;
    logic                         init_done_q;
    logic [1:0]                   occ_q, occ_d;
    logic                         pend_q;
    logic [1:0]                   fcnt_q, fcnt_d;
    logic [1:0][DATA_WIDTH-1:0]   buf_q, buf_d;

    logic req_fire, rd_fire, wr_fire, rsp_fire, pop_fifo, push_fifo;

    assign req_rdy   = cpurst_b && (state_q == StRun) && (occ_q != 2'd2);
    assign req_fire  = req_vld && req_rdy;
    assign rd_fire   = req_fire && !req_wr;
    assign wr_fire   = req_fire && req_wr && (req_be != '0);

    assign rsp_vld   = cpurst_b && (pend_q || (fcnt_q != 2'd0));
    assign rsp_fire  = rsp_vld && rsp_rdy;
    assign init_done = cpurst_b && init_done_q;

    always_comb begin
        rsp_rdata = '0;
        if (cpurst_b) begin
            if (fcnt_q != 2'd0) begin
                rsp_rdata = buf_q[0];
            end else if (pend_q) begin
                rsp_rdata = ram_q;
            end
        end
    end

    // Data arriving on ram_q must be captured now unless the bypass path consumes it this cycle.
    assign pop_fifo  = rsp_fire && (fcnt_q != 2'd0);
    assign push_fifo = pend_q && ((fcnt_q != 2'd0) || !rsp_rdy);

    always_comb begin
        buf_d  = buf_q;
        fcnt_d = fcnt_q;
        if (pop_fifo) begin
            buf_d[0] = buf_q[1];
            fcnt_d   = fcnt_q - 2'd1;
        end
        if (push_fifo) begin
            buf_d[fcnt_d[0]] = ram_q;
            fcnt_d           = fcnt_d + 2'd1;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (rd_fire && !rsp_fire) begin
            occ_d = occ_q + 2'd1;
        end else if (!rd_fire && rsp_fire) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_comb begin
        ram_cen  = 1'b1;
        ram_gwen = 1'b0;
        ram_wen  = '0;
        ram_a    = '0;
        ram_d    = '0;
        if (cpurst_b) begin
            if (state_q == StInit) begin
                ram_cen  = 1'b0;
                ram_gwen = 1'b1;
                ram_wen  = '1;
                ram_a    = cnt_q;
            end else if (rd_fire) begin
                ram_cen = 1'b0;
                ram_a   = req_addr;
            end else if (wr_fire) begin
                ram_cen  = 1'b0;
                ram_gwen = 1'b1;
                ram_a    = req_addr;
                ram_d    = req_wdata;
                for (int i = 0; i < BE_WIDTH; i++) begin
                    ram_wen[8*i +: 8] = {8{req_be[i]}};
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q     <= INIT_EN ? StInit : StRun;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
                end
                StRun:   init_done_q <= 1'b1;
                default: state_q     <= StInit;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            fcnt_q <= 2'd0;
            buf_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= rd_fire;
            fcnt_q <= fcnt_d;
            buf_q  <= buf_d;
        end
    end

endmodule
